// File: rtl/proc_control_unit_if.sv
// Data RAM handshake bundle between the microsequencer (master) and data RAM (slave).
interface proc_control_unit_if;
    logic dram_req;
    logic dram_we;
    logic dram_ack;

    modport master (output dram_req, output dram_we, input dram_ack);
    modport slave  (input dram_req, input dram_we, output dram_ack);
endinterface

// File: rtl/proc_control_unit.sv
// Microsequencer FSM: fetch/decode/execute control, ALU ops and data RAM handshake with watchdog.
// Optional build macro STEP_MODE_EN: returns to FETCH1 go through PAUSE, released by a step rising edge.
//
// state    | meaning
// IDLE     | waiting for start
// FETCH1   | read instruction RAM at PC
// FETCH2   | load IR, increment PC
// DECODE   | branch on opcode, flag illegal opcodes
// EX_ALU   | ADD / SUB / INCAR write-back
// EX_MOV   | AC -> R1
// EX_JMP   | TR -> PC when zero flag set
// MEM_REQ  | present data RAM request
// MEM_WAIT | hold request until ack or watchdog expiry
// MEM_WB   | DR -> AC after a load
// HALT     | stopped (END or watchdog), start resumes at FETCH1
// PAUSE    | single-step hold, step edge resumes at FETCH1
module proc_control_unit #(
    parameter int OPW      = 6,
    parameter int CBUS_W   = 10,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OPW-1:0]    opcode,
    input  logic              z_flag,
    input  logic              step,
    output logic              iram_rd,
    output logic              LDIR,
    output logic              PC_INC,
    output logic [CBUS_W-1:0] C_bus_ctrl_sig,
    output logic [3:0]        B_bus_sel,
    output logic [2:0]        alu_op,
    output logic              halted,
    output logic              mem_err,
    output logic              illegal_op,
    proc_control_unit_if.master mem
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH1   = 4'd1;
    localparam logic [3:0] S_FETCH2   = 4'd2;
    localparam logic [3:0] S_DECODE   = 4'd3;
    localparam logic [3:0] S_EX_ALU   = 4'd4;
    localparam logic [3:0] S_EX_MOV   = 4'd5;
    localparam logic [3:0] S_EX_JMP   = 4'd6;
    localparam logic [3:0] S_MEM_REQ  = 4'd7;
    localparam logic [3:0] S_MEM_WAIT = 4'd8;
    localparam logic [3:0] S_MEM_WB   = 4'd9;
    localparam logic [3:0] S_HALT     = 4'd10;
    localparam logic [3:0] S_PAUSE    = 4'd11;

`ifdef STEP_MODE_EN
    localparam logic [3:0] S_RET = S_PAUSE;
`else
    localparam logic [3:0] S_RET = S_FETCH1;
`endif

    localparam logic [OPW-1:0] OP_NOP    = OPW'('h00);
    localparam logic [OPW-1:0] OP_LDAC   = OPW'('h01);
    localparam logic [OPW-1:0] OP_STAC   = OPW'('h02);
    localparam logic [OPW-1:0] OP_MVACR1 = OPW'('h03);
    localparam logic [OPW-1:0] OP_ADD    = OPW'('h04);
    localparam logic [OPW-1:0] OP_SUB    = OPW'('h05);
    localparam logic [OPW-1:0] OP_JMPZ   = OPW'('h06);
    localparam logic [OPW-1:0] OP_INCAR  = OPW'('h07);
    localparam logic [OPW-1:0] OP_END    = OPW'('h3F);

    localparam logic [3:0] B_AR = 4'd0;
    localparam logic [3:0] B_R1 = 4'd1;
    localparam logic [3:0] B_TR = 4'd4;
    localparam logic [3:0] B_AC = 4'd5;
    localparam logic [3:0] B_DR = 4'd7;

    localparam int C_AR = 0;
    localparam int C_R1 = 1;
    localparam int C_AC = 5;
    localparam int C_PC = 6;
    localparam int C_DR = 7;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_INC  = 3'd3;

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [3:0]     r_state;
    logic [3:0]     w_next;
    logic [OPW-1:0] r_op;
    logic [CW-1:0]  r_wait_cnt;
    logic [CW-1:0]  w_wait_cnt_next;
    logic           r_mem_err;
    logic           r_step_q;
    logic           w_step_rise;
    logic           w_timeout;
    logic           w_legal;
    logic           w_resume;
    logic           w_store;

    assign w_wait_cnt_next = r_wait_cnt + CW'(1);
    assign w_timeout       = (r_state == S_MEM_WAIT) && !mem.dram_ack
                             && (w_wait_cnt_next == CW'(MAX_WAIT));
    assign w_step_rise     = step && !r_step_q;
    assign w_resume        = start && ((r_state == S_IDLE) || (r_state == S_HALT));
    assign w_store         = (r_op == OP_STAC);

    always_comb begin
        w_legal = 1'b0;
        case (opcode)
            OP_NOP, OP_LDAC, OP_STAC, OP_MVACR1,
            OP_ADD, OP_SUB, OP_JMPZ, OP_INCAR, OP_END: w_legal = 1'b1;
            default:                                  w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_FETCH1;
            S_FETCH1: w_next = S_FETCH2;
            S_FETCH2: w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LDAC, OP_STAC:          w_next = S_MEM_REQ;
                    OP_MVACR1:                 w_next = S_EX_MOV;
                    OP_ADD, OP_SUB, OP_INCAR:  w_next = S_EX_ALU;
                    OP_JMPZ:                   w_next = S_EX_JMP;
                    OP_END:                    w_next = S_HALT;
                    default:                   w_next = S_RET;
                endcase
            end
            S_EX_ALU, S_EX_MOV, S_EX_JMP, S_MEM_WB: w_next = S_RET;
            S_MEM_REQ: w_next = S_MEM_WAIT;
            S_MEM_WAIT: begin
                if (mem.dram_ack)   w_next = w_store ? S_RET : S_MEM_WB;
                else if (w_timeout) w_next = S_HALT;
            end
            S_HALT:   if (start) w_next = S_FETCH1;
            S_PAUSE:  if (w_step_rise) w_next = S_FETCH1;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
            r_step_q   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_step_q <= step;
            if (r_state == S_DECODE)
                r_op <= opcode;
            // Counter only lives inside MEM_WAIT; any exit returns it to zero.
            if ((r_state == S_MEM_WAIT) && (w_next == S_MEM_WAIT))
                r_wait_cnt <= w_wait_cnt_next;
            else
                r_wait_cnt <= '0;
            if (w_timeout)
                r_mem_err <= 1'b1;
            else if (w_resume)
                r_mem_err <= 1'b0;
        end
    end

    always_comb begin
        iram_rd        = 1'b0;
        LDIR           = 1'b0;
        PC_INC         = 1'b0;
        C_bus_ctrl_sig = '0;
        B_bus_sel      = 4'd0;
        alu_op         = ALU_PASS;
        mem.dram_req   = 1'b0;
        mem.dram_we    = 1'b0;
        halted         = 1'b0;
        illegal_op     = 1'b0;
        case (r_state)
            S_FETCH1: iram_rd = 1'b1;
            S_FETCH2: begin
                LDIR   = 1'b1;
                PC_INC = 1'b1;
            end
            S_DECODE: illegal_op = !w_legal;
            S_EX_ALU: begin
                case (r_op)
                    OP_INCAR: begin
                        B_bus_sel            = B_AR;
                        alu_op               = ALU_INC;
                        C_bus_ctrl_sig[C_AR] = 1'b1;
                    end
                    OP_SUB: begin
                        B_bus_sel            = B_R1;
                        alu_op               = ALU_SUB;
                        C_bus_ctrl_sig[C_AC] = 1'b1;
                    end
                    default: begin
                        B_bus_sel            = B_R1;
                        alu_op               = ALU_ADD;
                        C_bus_ctrl_sig[C_AC] = 1'b1;
                    end
                endcase
            end
            S_EX_MOV: begin
                B_bus_sel            = B_AC;
                C_bus_ctrl_sig[C_R1] = 1'b1;
            end
            S_EX_JMP: begin
                if (z_flag) begin
                    B_bus_sel            = B_TR;
                    C_bus_ctrl_sig[C_PC] = 1'b1;
                end
            end
            // Request, direction and address source stay fixed for the whole transfer.
            S_MEM_REQ, S_MEM_WAIT: begin
                mem.dram_req = 1'b1;
                mem.dram_we  = w_store;
                B_bus_sel    = w_store ? B_AC : B_AR;
                if ((r_state == S_MEM_WAIT) && !w_store)
                    C_bus_ctrl_sig[C_DR] = mem.dram_ack;
            end
            S_MEM_WB: begin
                B_bus_sel            = B_DR;
                alu_op               = ALU_PASS;
                C_bus_ctrl_sig[C_AC] = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign mem_err = r_mem_err;

endmodule

// File: tb/tb_proc_control_unit.sv
// Directed-vector bench: stimulus pushes hand-computed per-cycle outputs into a queue, a negedge monitor compares.
module tb_proc_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] opcode;
    logic       z_flag;
    logic       step;
    logic       iram_rd, LDIR, PC_INC, halted, mem_err, illegal_op;
    logic [9:0] C_bus_ctrl_sig;
    logic [3:0] B_bus_sel;
    logic [2:0] alu_op;

    proc_control_unit_if mif();

    proc_control_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .opcode         (opcode),
        .z_flag         (z_flag),
        .step           (step),
        .iram_rd        (iram_rd),
        .LDIR           (LDIR),
        .PC_INC         (PC_INC),
        .C_bus_ctrl_sig (C_bus_ctrl_sig),
        .B_bus_sel      (B_bus_sel),
        .alu_op         (alu_op),
        .halted         (halted),
        .mem_err        (mem_err),
        .illegal_op     (illegal_op),
        .mem            (mif.master)
    );

    always #5 clk = ~clk;

    logic [24:0] exp_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [24:0] ev(input logic ir, input logic ld, input logic pi,
                                       input logic [9:0] c, input logic [3:0] b,
                                       input logic [2:0] a, input logic rq, input logic we,
                                       input logic h, input logic me, input logic il);
        return {ir, ld, pi, c, b, a, rq, we, h, me, il};
    endfunction

    wire [24:0] w_act = {iram_rd, LDIR, PC_INC, C_bus_ctrl_sig, B_bus_sel, alu_op,
                         mif.dram_req, mif.dram_we, halted, mem_err, illegal_op};

    always @(negedge clk) begin
        logic [24:0] e;
        string       nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (w_act !== e) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", nm, w_act, e);
            end
            n_cmp++;
            if ($countones(C_bus_ctrl_sig) > 1) begin
                n_bad++;
                $display("FAIL %s_onehot: got C=%h want at most one bit", nm, C_bus_ctrl_sig);
            end
        end
    end

    task automatic tick(input logic rst, input logic st, input logic [5:0] op,
                        input logic z, input logic ack, input logic [24:0] e, input string nm);
        @(posedge clk);
        #1;
        rst_n        = rst;
        start        = st;
        opcode       = op;
        z_flag       = z;
        mif.dram_ack = ack;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    logic [24:0] Z, F1, F2;

    task automatic fetch_dec(input logic [5:0] op, input logic [24:0] e_dec, input string nm);
        tick(1, 0, op, 0, 0, F1, {nm, "_f1"});
        tick(1, 1, op, 0, 0, F2, {nm, "_f2"});   // start ignored outside IDLE/HALT
        tick(1, 0, op, 0, 0, e_dec, {nm, "_dec"});
    endtask

    initial begin
        Z  = '0;
        F1 = ev(1, 0, 0, 10'h000, 4'd0, 3'd0, 0, 0, 0, 0, 0);
        F2 = ev(0, 1, 1, 10'h000, 4'd0, 3'd0, 0, 0, 0, 0, 0);
        rst_n = 1'b0; start = 1'b0; opcode = '0; z_flag = 1'b0; step = 1'b0;
        mif.dram_ack = 1'b0;
        repeat (2) @(posedge clk);

        tick(0, 0, 6'h00, 0, 0, Z, "reset");
        tick(1, 0, 6'h00, 0, 0, Z, "idle_hold");
        tick(1, 1, 6'h04, 0, 0, Z, "idle_start");

        // ADD
        fetch_dec(6'h04, Z, "add");
        tick(1, 0, 6'h04, 0, 0, ev(0, 0, 0, 10'h020, 4'd1, 3'd1, 0, 0, 0, 0, 0), "add_ex");
        // NOP
        fetch_dec(6'h00, Z, "nop");
        // SUB
        fetch_dec(6'h05, Z, "sub");
        tick(1, 0, 6'h05, 0, 0, ev(0, 0, 0, 10'h020, 4'd1, 3'd2, 0, 0, 0, 0, 0), "sub_ex");
        // LDAC, ack during MEM_REQ ignored, ack on third wait cycle
        fetch_dec(6'h01, Z, "ldac");
        tick(1, 0, 6'h01, 0, 1, ev(0, 0, 0, 10'h000, 4'd0, 3'd0, 1, 0, 0, 0, 0), "ldac_req");
        tick(1, 0, 6'h01, 0, 0, ev(0, 0, 0, 10'h000, 4'd0, 3'd0, 1, 0, 0, 0, 0), "ldac_w1");
        tick(1, 0, 6'h01, 0, 0, ev(0, 0, 0, 10'h000, 4'd0, 3'd0, 1, 0, 0, 0, 0), "ldac_w2");
        tick(1, 0, 6'h01, 0, 1, ev(0, 0, 0, 10'h080, 4'd0, 3'd0, 1, 0, 0, 0, 0), "ldac_ack");
        tick(1, 0, 6'h01, 0, 0, ev(0, 0, 0, 10'h020, 4'd7, 3'd0, 0, 0, 0, 0, 0), "ldac_wb");
        // JMPZ z=0 then z=1
        fetch_dec(6'h06, Z, "jmp0");
        tick(1, 0, 6'h06, 0, 0, Z, "jmp0_ex");
        fetch_dec(6'h06, Z, "jmp1");
        tick(1, 0, 6'h06, 1, 0, ev(0, 0, 0, 10'h040, 4'd4, 3'd0, 0, 0, 0, 0, 0), "jmp1_ex");
        // MVACR1
        fetch_dec(6'h03, Z, "mov");
        tick(1, 0, 6'h03, 0, 0, ev(0, 0, 0, 10'h002, 4'd5, 3'd0, 0, 0, 0, 0, 0), "mov_ex");
        // INCAR
        fetch_dec(6'h07, Z, "inc");
        tick(1, 0, 6'h07, 0, 0, ev(0, 0, 0, 10'h001, 4'd0, 3'd3, 0, 0, 0, 0, 0), "inc_ex");
        // illegal 0x15
        fetch_dec(6'h15, ev(0, 0, 0, 10'h000, 4'd0, 3'd0, 0, 0, 0, 0, 1), "ill");
        // STAC with no ack: 15 wait cycles then HALT with mem_err
        fetch_dec(6'h02, Z, "stac");
        tick(1, 0, 6'h02, 0, 0, ev(0, 0, 0, 10'h000, 4'd5, 3'd0, 1, 1, 0, 0, 0), "stac_req");
        for (int i = 0; i < 15; i++)
            tick(1, 0, 6'h02, 0, 0, ev(0, 0, 0, 10'h000, 4'd5, 3'd0, 1, 1, 0, 0, 0), "stac_wait");
        tick(1, 0, 6'h02, 0, 0, ev(0, 0, 0, 10'h000, 4'd0, 3'd0, 0, 0, 1, 1, 0), "stac_halt");
        tick(1, 1, 6'h02, 0, 0, ev(0, 0, 0, 10'h000, 4'd0, 3'd0, 0, 0, 1, 1, 0), "stac_restart");
        // STAC with ack returns straight to FETCH1
        tick(1, 0, 6'h02, 0, 0, F1, "stac2_f1_err_clr");
        tick(1, 0, 6'h02, 0, 0, F2, "stac2_f2");
        tick(1, 0, 6'h02, 0, 0, Z, "stac2_dec");
        tick(1, 0, 6'h02, 0, 0, ev(0, 0, 0, 10'h000, 4'd5, 3'd0, 1, 1, 0, 0, 0), "stac2_req");
        tick(1, 0, 6'h02, 0, 1, ev(0, 0, 0, 10'h000, 4'd5, 3'd0, 1, 1, 0, 0, 0), "stac2_ack");
        // END
        fetch_dec(6'h3F, Z, "end");
        tick(1, 0, 6'h3F, 0, 0, ev(0, 0, 0, 10'h000, 4'd0, 3'd0, 0, 0, 1, 0, 0), "end_halt");
        tick(1, 1, 6'h3F, 0, 0, ev(0, 0, 0, 10'h000, 4'd0, 3'd0, 0, 0, 1, 0, 0), "end_start");
        // reset mid MEM_WAIT
        tick(1, 0, 6'h01, 0, 0, F1, "rst_f1");
        tick(1, 0, 6'h01, 0, 0, F2, "rst_f2");
        tick(1, 0, 6'h01, 0, 0, Z, "rst_dec");
        tick(1, 0, 6'h01, 0, 0, ev(0, 0, 0, 10'h000, 4'd0, 3'd0, 1, 0, 0, 0, 0), "rst_req");
        tick(1, 0, 6'h01, 0, 0, ev(0, 0, 0, 10'h000, 4'd0, 3'd0, 1, 0, 0, 0, 0), "rst_wait");
        tick(0, 0, 6'h01, 0, 0, Z, "rst_async");
        tick(1, 0, 6'h01, 0, 1, Z, "rst_idle");
        tick(1, 0, 6'h01, 0, 0, Z, "rst_idle2");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/proc_control_unit.md
Name: proc_control_unit

Overview:
- Microsequencer FSM for the processor datapath.
- Drives the register unit's IR load (LDIR), PC increment (PC_INC), the one-hot C-bus write enables and the B-bus source select.
- Issues ALU ops and runs a req/ack handshake to data RAM with a wait-cycle watchdog.
- Sits between instruction RAM / IR and the register file; the top level wires the opcode from IR into it.

Parameters:
- OPW, 6: opcode width, matching the IR output.
- CBUS_W, 10: number of C-bus write enables.
- MAX_WAIT, 15: maximum cycles to wait for dram_ack before error.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; leaves IDLE/HALT into FETCH1.
- opcode  input  OPW  current IR opcode.
- z_flag  input  1  ALU zero flag.
- dram_ack  input  1  data RAM done.
- step  input  1  single-step advance; ignored unless STEP_MODE_EN.
- iram_rd  output  1  instruction RAM read at PC.
- LDIR  output  1  load IR.
- PC_INC  output  1  increment PC.
- C_bus_ctrl_sig  output  CBUS_W  one-hot write enables. Bit map: 0 AR, 1 R1, 2 R2, 3 R3, 4 TR, 5 AC, 6 PC, 7 DR, 8 MAR, 9 OUT.
- B_bus_sel  output  4  B-bus source code; same numbering as the C-bus bits.
- alu_op  output  3  0 PASS, 1 ADD, 2 SUB, 3 INC.
- dram_req  output  1  memory request.
- dram_we  output  1  memory write when dram_req is high.
- halted  output  1  FSM in HALT.
- mem_err  output  1  sticky watchdog error; cleared by reset or start.
- illegal_op  output  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Reset: all outputs 0; state IDLE; wait counter 0.
  - rst_n is asynchronous. Asserting it mid-operation drops dram_req in the same cycle.
- Output timing: outputs are Moore decodes of the registered state. The only exception is C_bus_ctrl_sig[7], which is asserted in MEM_WAIT gated by dram_ack.
- C_bus_ctrl_sig is never multi-hot.
- States: IDLE, FETCH1, FETCH2, DECODE, EX_ALU, EX_MOV, EX_JMP, MEM_REQ, MEM_WAIT, MEM_WB, HALT, PAUSE.
- IDLE: stays until start=1, then goes to FETCH1.
- Fetch/decode:
  - FETCH1: iram_rd=1.
  - FETCH2: LDIR=1, PC_INC=1.
  - DECODE: no outputs; branches on opcode.
- Opcodes (anything else is illegal):
  - 0x00 NOP: DECODE -> FETCH1.
  - 0x01 LDAC: MEM_REQ (dram_req=1, B_bus_sel=AR) -> MEM_WAIT -> MEM_WB (B_bus_sel=DR, alu_op PASS, C[5]=1).
  - 0x02 STAC: MEM_REQ with dram_we=1, B_bus_sel=AC -> MEM_WAIT -> FETCH1.
  - 0x03 MVACR1: EX_MOV; B_bus_sel=AC, C[1]=1.
  - 0x04 ADD / 0x05 SUB: EX_ALU; B_bus_sel=R1, alu_op ADD/SUB, C[5]=1.
  - 0x06 JMPZ: EX_JMP. If z_flag=1: B_bus_sel=TR, C[6]=1. If z_flag=0: no write.
  - 0x07 INCAR: EX_ALU; B_bus_sel=AR, alu_op INC, C[0]=1.
  - 0x3F END: HALT.
  - Illegal opcode: pulse illegal_op in DECODE, then behave as NOP.
- Return path: EX_* and MEM_WB return to FETCH1.
- Latency: NOP 3 cycles; ALU/MOV/JMP 4 cycles; LDAC 6 cycles with ack in the first MEM_WAIT cycle.
- Handshake:
  - dram_req and dram_we are held constant from MEM_REQ through MEM_WAIT until dram_ack=1 is sampled in MEM_WAIT.
  - dram_ack while in MEM_REQ is ignored.
  - The wait counter increments every MEM_WAIT cycle. When it reaches MAX_WAIT without ack: set mem_err, go to HALT, drop dram_req.
  - Counter clears on leaving MEM_WAIT.
- HALT: halted=1.
  - start=1 clears mem_err and goes to FETCH1; PC is not touched.
  - start is ignored in all states other than IDLE and HALT.

Optional Feature:
- STEP_MODE_EN defined: every path that would return to FETCH1 (except from IDLE/HALT) goes to PAUSE instead.
  - PAUSE holds all outputs 0 and goes to FETCH1 on a step rising edge, detected with a registered copy of step.
- Not defined: PAUSE is unreachable and step is unused.

Test Plan:
- Reset mid-MEM_WAIT with dram_req=1 -> dram_req=0 immediately; after release, state IDLE, all outputs 0.
- start, then opcode=0x04 -> cycle 1 iram_rd=1; cycle 2 LDIR=PC_INC=1; cycle 4 C_bus_ctrl_sig=10'h020, alu_op=1, B_bus_sel=1.
- opcode=0x01, ack after 3 wait cycles -> dram_req high 4 cycles; C[7] on the ack cycle; next cycle C=10'h020, B_bus_sel=7.
- opcode=0x02, no ack -> after 15 wait cycles mem_err=1, halted=1, dram_req=0; start clears mem_err.
- opcode=0x06 with z_flag=0 then 1 -> C_bus_ctrl_sig stays 0, then 10'h040 with B_bus_sel=4.
- opcode=0x15 -> illegal_op one-cycle pulse, next fetch follows; opcode=0x3F -> halted=1 until start. With STEP_MODE_EN: PAUSE until a step edge.
